// File: rtl/program_counter_pkg.sv
// Shared types and constants for the program counter and the branch-target controller.
package program_counter_pkg;

    localparam int PC_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Selects which source feeds the next PC value.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_ADD  = 2'd2,
        SEL_LOAD = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/program_counter_if.sv
// Control/status bundle between the fetch controller (master) and the program counter (slave).
// Carries the Err flag only when PC_WRAP_DETECT_EN is defined.
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int D = PC_W
);
    logic         Start;
    logic [D-1:0] StartAddr;
    logic         Branch;
    logic [D-1:0] Target;
    logic         Stall;
    logic         Halt;
    logic [D-1:0] PC;
    logic         Running;
    logic         Done;
`ifdef PC_WRAP_DETECT_EN
    logic         Err;

    modport master (output Start, StartAddr, Branch, Target, Stall, Halt,
                    input  PC, Running, Done, Err);
    modport slave  (input  Start, StartAddr, Branch, Target, Stall, Halt,
                    output PC, Running, Done, Err);
`else
    modport master (output Start, StartAddr, Branch, Target, Stall, Halt,
                    input  PC, Running, Done);
    modport slave  (input  Start, StartAddr, Branch, Target, Stall, Halt,
                    output PC, Running, Done);
`endif
endinterface

// File: rtl/program_counter_pc_next_calc.sv
// Combinational next-PC mux/adder: hold, +1, +signed Target, or StartAddr, all modulo 2^D.
// With PC_WRAP_DETECT_EN, also flags results that leave [0, 2^D-1] before truncation.
module pc_next_calc
    import program_counter_pkg::*;
#(
    parameter int D = PC_W
) (
    input  pc_sel_t      i_sel,
    input  logic [D-1:0] i_pc,
    input  logic [D-1:0] i_target,
    input  logic [D-1:0] i_start_addr,
    output logic [D-1:0] o_next_pc
`ifdef PC_WRAP_DETECT_EN
    ,
    output logic         o_wrap
`endif
);

    logic [D-1:0] w_addend;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_addend  = (i_sel == SEL_INC) ? D'(1) : i_target;
        o_next_pc = i_pc;
        case (i_sel)
            SEL_LOAD:         o_next_pc = i_start_addr;
            SEL_INC, SEL_ADD: o_next_pc = i_pc + w_addend;
            default:          o_next_pc = i_pc;
        endcase
    end

`ifdef PC_WRAP_DETECT_EN
    // Two guard bits: PC is unsigned, Target signed, so the exact sum spans [-2^(D-1), 2^D + 2^(D-1)).
    logic [D+1:0] w_wide_sum;

    always_comb begin
        if (i_sel == SEL_INC)
            w_wide_sum = {2'b00, i_pc} + (D+2)'(1);
        else
            w_wide_sum = {2'b00, i_pc} + {{2{i_target[D-1]}}, i_target};
        o_wrap = ((i_sel == SEL_INC) || (i_sel == SEL_ADD)) && (w_wide_sum[D+1:D] != 2'b00);
    end
`endif

endmodule

// File: rtl/program_counter.sv
// Program counter with IDLE/RUN/DONE sequencing; priority Start > Halt > Stall > Branch > +1.
// Optional sticky wrap error (Err) enabled by defining PC_WRAP_DETECT_EN.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int D = PC_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    program_counter_if.slave   bus
);

    pc_state_t    r_state;
    logic [D-1:0] r_pc;
    logic         r_running;
    logic         r_done;
    pc_sel_t      w_sel;
    logic [D-1:0] w_next_pc;
`ifdef PC_WRAP_DETECT_EN
    logic         r_err;
    logic         w_wrap;
`endif

    always_comb begin
        w_sel = SEL_HOLD;
        if (bus.Start)
            w_sel = SEL_LOAD;
        else if (r_state == RUN) begin
            if (bus.Halt || bus.Stall)
                w_sel = SEL_HOLD;
            else if (bus.Branch)
                w_sel = SEL_ADD;
            else
                w_sel = SEL_INC;
        end
    end

    pc_next_calc #(.D(D)) u_next (
        .i_sel        (w_sel),
        .i_pc         (r_pc),
        .i_target     (bus.Target),
        .i_start_addr (bus.StartAddr),
        .o_next_pc    (w_next_pc)
`ifdef PC_WRAP_DETECT_EN
        ,
        .o_wrap       (w_wrap)
`endif
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
`ifdef PC_WRAP_DETECT_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_pc <= w_next_pc;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.Start && bus.Halt) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
`ifdef PC_WRAP_DETECT_EN
            if (bus.Start)
                r_err <= 1'b0;
            else if (w_wrap)
                r_err <= 1'b1;
`endif
        end
    end

    assign bus.PC      = r_pc;
    assign bus.Running = r_running;
    assign bus.Done    = r_done;
`ifdef PC_WRAP_DETECT_EN
    assign bus.Err     = r_err;
`endif

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter D, default 12, meaning PC / branch-offset width in bits (instruction-memory address width).
REQ-002 Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  pulse: load StartAddr and begin (or restart) execution.
REQ-005 StartAddr  input  D  program entry address loaded on Start.
REQ-006 Branch  input  1  take branch this cycle: apply Target as signed offset.
REQ-007 Target  input  D  signed two's-complement offset from the branch-target controller stage.
REQ-008 Stall  input  1  hold PC this cycle.
REQ-009 Halt  input  1  current instruction is halt; stop fetching.
REQ-010 PC  output  D  current instruction address.
REQ-011 Running  output  1  high while in RUN state.
REQ-012 Done  output  1  high while in DONE state.

Function
REQ-013 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: PC holds; Start=1 -> PC<=StartAddr, state<=RUN at the same edge (1-cycle latency); all other inputs ignored.
REQ-015 RUN per-edge priority: Start > Halt > Stall > Branch > sequential increment.
REQ-016 RUN, Start=1: PC<=StartAddr, stay RUN (restart mid-program).
REQ-017 RUN, Halt=1: PC holds, state<=DONE; Done=1 from the next cycle.
REQ-018 RUN, Stall=1 (no Halt/Start): PC holds; Branch ignored that cycle, not queued.
REQ-019 RUN, Branch=1: PC<=(PC+Target) mod 2^D; Target=0 holds PC (controller's default "hold PC").
REQ-020 RUN, no control asserted: PC<=(PC+1) mod 2^D; 2^D-1 wraps to 0.
REQ-021 DONE: PC and Done held; Branch/Stall/Halt ignored; Start=1 -> PC<=StartAddr, state<=RUN, Done clears on the same edge.
REQ-022 Running=1 iff state==RUN; Done=1 iff state==DONE; never both.
REQ-023 Arithmetic D bits wide, carry discarded; Target is never re-extended inside this block.

Reset
REQ-024 Reset_n low asynchronously forces PC=0, state=IDLE, Running=0, Done=0 (and Err=0 when present), regardless of Clk.
REQ-025 Reset asserted mid-RUN aborts immediately; after release the block waits in IDLE for Start.
REQ-026 Start sampled on the first rising edge after Reset_n rises is honoured.

Configuration
REQ-027 Macro PC_WRAP_DETECT_EN: when defined, adds output Err (1 bit), sticky, set on any RUN update whose unbounded result lies outside [0, 2^D-1] (signed branch over/underflow or increment past 2^D-1); cleared only by reset or Start.
REQ-028 Without PC_WRAP_DETECT_EN: no Err port, no detection logic; wrap behaviour per REQ-019/020 unchanged.

Structure
REQ-029 Shared package holds pc_state_t enum {IDLE, RUN, DONE} and the PC width constant (12), also used by the branch-target controller.
REQ-030 One sub-module, pc_next_calc: combinational next-PC mux/adder (hold / +1 / +Target / StartAddr) with wrap flag; FSM and registers stay in program_counter.

Verification (D=12)
REQ-031 Reset_n=0 mid-clock -> PC=0x000, Running=0, Done=0 without waiting for an edge.
REQ-032 IDLE, Start=1, StartAddr=0x010, then 3 idle cycles -> PC 0x010, 0x011, 0x012, 0x013; Running=1.
REQ-033 PC=0x100, Branch=1, Target=0xF9B (-101) -> PC=0x09B; next edge Branch=1, Target=0x000 -> PC stays 0x09B.
REQ-034 PC=0x050, Stall=1 and Branch=1, Target=0x009 -> PC stays 0x050; next cycle Stall=0, Branch=1 -> 0x059.
REQ-035 Halt=1 with Stall=1 -> DONE, Done=1, PC held; Start=1, StartAddr=0x200 -> PC=0x200, Running=1, Done=0.
REQ-036 PC_WRAP_DETECT_EN defined: PC=0xFFF, sequential step -> PC=0x000, Err=1, stays 1 until Start; PC=0x005 + Target 0xFF0 (-16) -> PC=0xFF5, Err=1.
